// File: rtl/fwd_hazard_unit.sv
// ID-stage operand forwarding with load-use / slow-memory hazard detection and stall tracking.
// Optional statistics counters are enabled with the FWD_HAZARD_STATS_EN macro.
module fwd_hazard_unit #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned MAX_STALL = 16,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [NUM_RD*REG_AW-1:0]   id_rs,
  input  logic [NUM_RD-1:0]          id_rs_used,
  input  logic [NUM_RD*DATA_W-1:0]   id_data,
  input  logic                       exe_we,
  input  logic [REG_AW-1:0]          exe_dreg,
  input  logic [DATA_W-1:0]          exe_data,
  input  logic                       exe_is_load,
  input  logic                       mem_we,
  input  logic [REG_AW-1:0]          mem_dreg,
  input  logic [DATA_W-1:0]          mem_data,
  input  logic                       mem_is_load,
  input  logic                       mem_data_ready,
  input  logic                       wb_we,
  input  logic [REG_AW-1:0]          wb_dreg,
  input  logic [DATA_W-1:0]          wb_data,
  output logic [NUM_RD*DATA_W-1:0]   fwd_data,
  output logic [NUM_RD*2-1:0]        fwd_sel,
  output logic                       stall,
  output logic [CNT_W-1:0]           stall_cnt,
`ifdef FWD_HAZARD_STATS_EN
  output logic [31:0]                stat_stall_cycles,
  output logic [31:0]                stat_lu_events,
  output logic [31:0]                stat_fwd_events,
`endif
  output logic                       stall_timeout
);

  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_STALL_LU  = 2'd1,
    ST_STALL_MEM = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_RD-1:0]   haz_lu;
  logic [NUM_RD-1:0]   haz_mem;
  logic [REG_AW-1:0]   src;
  logic                live;
  logic                lu_any;
  logic                mem_any;

  // Per-port source selection: youngest matching producer wins.
  always_comb begin
    fwd_sel  = '0;
    fwd_data = id_data;
    haz_lu   = '0;
    haz_mem  = '0;
    src      = '0;
    live     = 1'b0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      src  = id_rs[k*REG_AW +: REG_AW];
      live = id_rs_used[k] && (src != '0);
      if (live && exe_we && (exe_dreg == src)) begin
        if (exe_is_load) begin
          haz_lu[k] = 1'b1;
        end else begin
          fwd_sel[k*SEL_W +: SEL_W]   = 2'd3;
          fwd_data[k*DATA_W +: DATA_W] = exe_data;
        end
      end else if (live && mem_we && (mem_dreg == src)) begin
        if (mem_is_load && !mem_data_ready) begin
          haz_mem[k] = 1'b1;
        end else begin
          fwd_sel[k*SEL_W +: SEL_W]   = 2'd2;
          fwd_data[k*DATA_W +: DATA_W] = mem_data;
        end
      end else if (live && wb_we && (wb_dreg == src)) begin
        fwd_sel[k*SEL_W +: SEL_W]   = 2'd1;
        fwd_data[k*DATA_W +: DATA_W] = wb_data;
      end
    end
    if (rst) begin
      fwd_sel  = '0;
      fwd_data = id_data;
    end
  end

  assign lu_any  = id_valid && (|haz_lu);
  assign mem_any = id_valid && (|haz_mem);
  assign stall   = !rst && (lu_any || mem_any);

  // Hazard-class state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Load-use takes precedence when both hazard classes are present.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN, ST_STALL_LU: begin
        if (lu_any)       state_d = ST_STALL_LU;
        else if (mem_any) state_d = ST_STALL_MEM;
        else              state_d = ST_RUN;
      end
      ST_STALL_MEM: begin
        if (!lu_any && !mem_any) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Consecutive-stall counter and sticky timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (stall) begin
        if (stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_W'(1);
        if (stall_cnt == CNT_W'(MAX_STALL - 1)) stall_timeout <= 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic fwd_hit;
  assign fwd_hit = id_valid && !stall && (fwd_sel != '0);

  // Saturating event statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_cycles <= '0;
      stat_lu_events    <= '0;
      stat_fwd_events   <= '0;
    end else begin
      if (stall && (stat_stall_cycles != 32'hFFFF_FFFF))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if ((state_q == ST_RUN) && (state_d == ST_STALL_LU) && (stat_lu_events != 32'hFFFF_FFFF))
        stat_lu_events <= stat_lu_events + 32'd1;
      if (fwd_hit && (stat_fwd_events != 32'hFFFF_FFFF))
        stat_fwd_events <= stat_fwd_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_fwd_hazard_unit;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned NUM_RD    = 2;
  localparam int unsigned MAX_STALL = 16;
  localparam int unsigned CNT_W     = 8;

  logic                     clk, rst, id_valid;
  logic [NUM_RD*REG_AW-1:0] id_rs;
  logic [NUM_RD-1:0]        id_rs_used;
  logic [NUM_RD*DATA_W-1:0] id_data;
  logic                     exe_we, exe_is_load, mem_we, mem_is_load, mem_data_ready, wb_we;
  logic [REG_AW-1:0]        exe_dreg, mem_dreg, wb_dreg;
  logic [DATA_W-1:0]        exe_data, mem_data, wb_data;
  logic [NUM_RD*DATA_W-1:0] fwd_data;
  logic [NUM_RD*2-1:0]      fwd_sel;
  logic                     stall, stall_timeout;
  logic [CNT_W-1:0]         stall_cnt;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stat_stall_cycles, stat_lu_events, stat_fwd_events;
`endif

  int checks = 0;
  int failures = 0;

  fwd_hazard_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_RD(NUM_RD),
                    .MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_data(id_data), .exe_we(exe_we), .exe_dreg(exe_dreg), .exe_data(exe_data),
    .exe_is_load(exe_is_load), .mem_we(mem_we), .mem_dreg(mem_dreg), .mem_data(mem_data),
    .mem_is_load(mem_is_load), .mem_data_ready(mem_data_ready), .wb_we(wb_we),
    .wb_dreg(wb_dreg), .wb_data(wb_data), .fwd_data(fwd_data), .fwd_sel(fwd_sel),
    .stall(stall), .stall_cnt(stall_cnt),
`ifdef FWD_HAZARD_STATS_EN
    .stat_stall_cycles(stat_stall_cycles), .stat_lu_events(stat_lu_events),
    .stat_fwd_events(stat_fwd_events),
`endif
    .stall_timeout(stall_timeout));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what one read port must see, from the stage-priority rules.
  function automatic void model_port(input int k, output logic [1:0] sel,
                                     output logic [31:0] data, output logic lu, output logic mh);
    logic [REG_AW-1:0] r;
    r = id_rs[k*REG_AW +: REG_AW];
    sel = 2'd0; data = id_data[k*DATA_W +: DATA_W]; lu = 1'b0; mh = 1'b0;
    if (id_rs_used[k] && r != 0) begin
      if (exe_we && exe_dreg == r) begin
        if (exe_is_load) lu = 1'b1; else begin sel = 2'd3; data = exe_data; end
      end else if (mem_we && mem_dreg == r) begin
        if (mem_is_load && !mem_data_ready) mh = 1'b1; else begin sel = 2'd2; data = mem_data; end
      end else if (wb_we && wb_dreg == r) begin
        sel = 2'd1; data = wb_data;
      end
    end
    if (rst) begin sel = 2'd0; data = id_data[k*DATA_W +: DATA_W]; end
  endfunction

  function automatic void model_haz(output logic lu_any, output logic mem_any);
    logic [1:0] s; logic [31:0] d; logic lu, mh;
    lu_any = 1'b0; mem_any = 1'b0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      model_port(k, s, d, lu, mh);
      lu_any  = lu_any  | (lu & id_valid);
      mem_any = mem_any | (mh & id_valid);
    end
  endfunction

  // Model of the registered outputs.
  int   m_cnt = 0;
  logic m_to = 1'b0;
  bit   model_valid = 1'b0;
  int   m_state = 0;
  longint m_stall_cycles = 0, m_lu_events = 0, m_fwd_events = 0;

  always @(posedge clk) begin
    logic lu_any, mem_any, st, anyfwd;
    logic [1:0] s; logic [31:0] d; logic lu, mh;
    int nxt;
    model_haz(lu_any, mem_any);
    st = !rst && (lu_any || mem_any);
    anyfwd = 1'b0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      model_port(k, s, d, lu, mh);
      if (s != 0) anyfwd = 1'b1;
    end
    if (rst) begin
      m_cnt = 0; m_to = 1'b0; m_state = 0; model_valid = 1'b1;
      m_stall_cycles = 0; m_lu_events = 0; m_fwd_events = 0;
    end else begin
      if (st) begin
        if (m_cnt == MAX_STALL - 1) m_to = 1'b1;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
        m_stall_cycles++;
      end else begin
        m_cnt = 0;
      end
      if (m_state == 2) nxt = (lu_any || mem_any) ? 2 : 0;
      else nxt = lu_any ? 1 : (mem_any ? 2 : 0);
      if (m_state == 0 && nxt == 1) m_lu_events++;
      m_state = nxt;
      if (id_valid && !st && anyfwd) m_fwd_events++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic lu_any, mem_any;
    logic [1:0] s; logic [31:0] d; logic lu, mh;
    model_haz(lu_any, mem_any);
    check("stall", 64'(stall), 64'(!rst && (lu_any || mem_any)));
    for (int k = 0; k < int'(NUM_RD); k++) begin
      model_port(k, s, d, lu, mh);
      if (!lu && !mh) begin
        check("fwd_sel", 64'(fwd_sel[k*2 +: 2]), 64'(s));
        check("fwd_data", 64'(fwd_data[k*DATA_W +: DATA_W]), 64'(d));
      end
    end
    if (model_valid) begin
      check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      check("stall_timeout", 64'(stall_timeout), 64'(m_to));
`ifdef FWD_HAZARD_STATS_EN
      check("stat_stall_cycles", 64'(stat_stall_cycles), 64'(m_stall_cycles));
      check("stat_lu_events", 64'(stat_lu_events), 64'(m_lu_events));
      check("stat_fwd_events", 64'(stat_fwd_events), 64'(m_fwd_events));
`endif
    end
  end

  task automatic idle();
    id_valid = 1'b1; id_rs = '0; id_rs_used = '1;
    id_data = {$urandom, $urandom};
    exe_we = 0; exe_dreg = 0; exe_data = 0; exe_is_load = 0;
    mem_we = 0; mem_dreg = 0; mem_data = 0; mem_is_load = 0; mem_data_ready = 0;
    wb_we = 0; wb_dreg = 0; wb_data = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem_hazard();
    idle();
    id_rs[0 +: REG_AW] = 5'd3;
    mem_we = 1; mem_dreg = 5'd3; mem_is_load = 1; mem_data_ready = 0; mem_data = 32'h3333;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    exe_we = 1; exe_dreg = 5'd7; exe_is_load = 1; id_rs[0 +: REG_AW] = 5'd7;
    @(negedge clk);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_sel", 64'(fwd_sel), 64'd0);
    check("rst_data", 64'(fwd_data), 64'(id_data));
    next_cycle(); next_cycle();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("reset_cnt", 64'(stall_cnt), 64'd0);
    check("reset_to", 64'(stall_timeout), 64'd0);

    // Priority EXE > MEM > WB
    next_cycle();
    idle();
    id_rs[0 +: REG_AW] = 5'd5;
    exe_we = 1; exe_dreg = 5; exe_data = 32'hA;
    mem_we = 1; mem_dreg = 5; mem_data = 32'hB;
    wb_we = 1; wb_dreg = 5; wb_data = 32'hC;
    @(negedge clk);
    check("prio_exe_sel", 64'(fwd_sel[1:0]), 64'd3);
    check("prio_exe_data", 64'(fwd_data[31:0]), 64'hA);
    check("prio_exe_stall", 64'(stall), 64'd0);
    next_cycle(); exe_we = 0;
    @(negedge clk);
    check("prio_mem_sel", 64'(fwd_sel[1:0]), 64'd2);
    check("prio_mem_data", 64'(fwd_data[31:0]), 64'hB);
    next_cycle(); mem_we = 0;
    @(negedge clk);
    check("prio_wb_sel", 64'(fwd_sel[1:0]), 64'd1);
    check("prio_wb_data", 64'(fwd_data[31:0]), 64'hC);

    // r0 never matches; unused port never matches
    next_cycle(); idle();
    exe_we = 1; exe_dreg = 0; exe_data = 32'hDEAD;
    @(negedge clk);
    check("r0_sel", 64'(fwd_sel[1:0]), 64'd0);
    check("r0_data", 64'(fwd_data[31:0]), 64'(id_data[31:0]));
    next_cycle(); idle();
    id_rs[0 +: REG_AW] = 5'd5; id_rs_used = 2'b10;
    exe_we = 1; exe_dreg = 5; exe_is_load = 1;
    @(negedge clk);
    check("unused_sel", 64'(fwd_sel[1:0]), 64'd0);
    check("unused_stall", 64'(stall), 64'd0);

    // Load-use then MEM forward
    next_cycle(); idle();
    id_rs[REG_AW +: REG_AW] = 5'd7;
    exe_we = 1; exe_dreg = 7; exe_is_load = 1;
    @(negedge clk);
    check("lu_stall", 64'(stall), 64'd1);
    next_cycle(); idle();
    id_rs[REG_AW +: REG_AW] = 5'd7;
    mem_we = 1; mem_dreg = 7; mem_is_load = 1; mem_data_ready = 1; mem_data = 32'h77;
    @(negedge clk);
    check("lu_cnt1", 64'(stall_cnt), 64'd1);
    check("lu_release_stall", 64'(stall), 64'd0);
    check("lu_release_sel", 64'(fwd_sel[3:2]), 64'd2);
    check("lu_release_data", 64'(fwd_data[63:32]), 64'h77);
    next_cycle(); idle();
    @(negedge clk);
    check("lu_cnt0", 64'(stall_cnt), 64'd0);

    // Slow memory for 4 cycles
    next_cycle(); set_mem_hazard();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("slow_stall", 64'(stall), 64'd1);
      check("slow_cnt", 64'(stall_cnt), 64'(i));
      next_cycle();
    end
    mem_data_ready = 1;
    @(negedge clk);
    check("slow_cnt4", 64'(stall_cnt), 64'd4);
    check("slow_release_stall", 64'(stall), 64'd0);
    check("slow_release_sel", 64'(fwd_sel[1:0]), 64'd2);
    check("slow_release_data", 64'(fwd_data[31:0]), 64'h3333);

    // Timeout after 16 stalled edges, sticky until rst
    next_cycle(); set_mem_hazard();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("to_cnt", 64'(stall_cnt), 64'(i));
      check("to_flag", 64'(stall_timeout), 64'(i >= 16));
      next_cycle();
    end
    idle();
    next_cycle();
    @(negedge clk);
    check("to_sticky", 64'(stall_timeout), 64'd1);
    check("to_cnt_clear", 64'(stall_cnt), 64'd0);
    next_cycle(); rst = 1;
    next_cycle(); rst = 0;
    @(negedge clk);
    check("to_rst_flag", 64'(stall_timeout), 64'd0);
    check("to_rst_cnt", 64'(stall_cnt), 64'd0);

    // Reset in the middle of a memory stall
    next_cycle(); set_mem_hazard();
    next_cycle(); next_cycle(); next_cycle();
    rst = 1;
    @(negedge clk);
    check("mid_rst_stall", 64'(stall), 64'd0);
    next_cycle(); rst = 0; idle();
    @(negedge clk);
    check("mid_rst_cnt", 64'(stall_cnt), 64'd0);
`ifdef FWD_HAZARD_STATS_EN
    check("mid_rst_stat_stall", 64'(stat_stall_cycles), 64'd0);
    check("mid_rst_stat_lu", 64'(stat_lu_events), 64'd0);
    check("mid_rst_stat_fwd", 64'(stat_fwd_events), 64'd0);
`endif

    // Randomized traffic over a small register set
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      rst = ($urandom_range(0, 99) < 2);
      id_valid = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < int'(NUM_RD); k++)
        id_rs[k*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 5));
      id_rs_used = NUM_RD'($urandom);
      id_data = {$urandom, $urandom};
      exe_we = 1'($urandom); exe_dreg = REG_AW'($urandom_range(0, 5));
      exe_data = $urandom; exe_is_load = ($urandom_range(0, 3) == 0);
      mem_we = 1'($urandom); mem_dreg = REG_AW'($urandom_range(0, 5));
      mem_data = $urandom; mem_is_load = 1'($urandom);
      mem_data_ready = ($urandom_range(0, 9) < 4);
      wb_we = 1'($urandom); wb_dreg = REG_AW'($urandom_range(0, 5)); wb_data = $urandom;
    end
    next_cycle();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
